// File: rtl/dmem_responder.sv
// Word-organised data-memory responder: accepts a sel request, waits WAIT_CYCLES, then pulses ack.
// Optional address checking (err port) is built when DMEM_ADDR_CHECK_EN is defined.
module dmem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic        we,
  input  logic [3:0]  byte_en,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        ack,
  output logic        busy
`ifdef DMEM_ADDR_CHECK_EN
  ,
  output logic        err
`endif
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic          lat_we;
  logic [3:0]    lat_be;
  logic [31:0]   lat_addr;
  logic [31:0]   lat_din;

  logic [31:0]   mem [DEPTH];

  logic          req_we;
  logic [3:0]    req_be;
  logic [31:0]   req_addr;
  logic [31:0]   req_din;
  logic [AW-1:0] widx;
  logic          enter_ack;
  logic          acc_err;
  logic          wr_go;
  logic [31:0]   rd_word;

  // With zero wait states the access completes on the accept edge, so it must use the live inputs.
  always_comb begin
    req_we   = lat_we;
    req_be   = lat_be;
    req_addr = lat_addr;
    req_din  = lat_din;
    if (state == ST_IDLE) begin
      req_we   = we;
      req_be   = byte_en;
      req_addr = addr;
      req_din  = din;
    end
  end

  always_comb begin
    enter_ack = 1'b0;
    case (state)
      ST_IDLE: enter_ack = sel && (WAIT_CYCLES == 0);
      ST_WAIT: enter_ack = sel && (cnt == 4'd0);
      default: enter_ack = 1'b0;
    endcase
  end

  assign widx = req_addr[AW+1:2];

`ifdef DMEM_ADDR_CHECK_EN
  assign acc_err = (req_addr[1:0] != 2'b00) || ({1'b0, req_addr} >= (33'(DEPTH) * 33'd4));
`else
  // Without checking, the byte offset and bits above the RAM size are simply don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};
  assign acc_err = 1'b0;
`endif

  // rst_n gates the write so a reset landing on the ack edge cannot commit it.
  assign wr_go   = enter_ack && req_we && !acc_err && rst_n;
  assign rd_word = mem[widx];

  always_ff @(posedge clk) begin
    if (wr_go) begin
      for (int b = 0; b < 4; b++) begin
        if (req_be[b]) mem[widx][8*b +: 8] <= req_din[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      ack      <= 1'b0;
      busy     <= 1'b0;
      dout     <= 32'd0;
      lat_we   <= 1'b0;
      lat_be   <= 4'd0;
      lat_addr <= 32'd0;
      lat_din  <= 32'd0;
`ifdef DMEM_ADDR_CHECK_EN
      err      <= 1'b0;
`endif
    end else begin
      ack <= 1'b0;
`ifdef DMEM_ADDR_CHECK_EN
      err <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (sel) begin
            lat_we   <= we;
            lat_be   <= byte_en;
            lat_addr <= addr;
            lat_din  <= din;
            busy     <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state <= ST_ACK;
            end else begin
              cnt   <= CNT_LOAD;
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!sel) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (cnt == 4'd0) begin
            state <= ST_ACK;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (enter_ack) begin
        ack <= 1'b1;
`ifdef DMEM_ADDR_CHECK_EN
        err <= acc_err;
`endif
        if (acc_err)      dout <= 32'd0;
        else if (!req_we) dout <= rd_word;
      end
    end
  end

endmodule
